// File: rtl/servo_pkg.sv
// Shared constants and types for the four-channel servo PWM generator.
// All timing values are expressed in system clock cycles.
package servo_pkg;

   localparam int CLOCK_FREQ   = 50_000_000;
   localparam int FRAME_HZ     = 50;
   localparam int MIN_PULSE_US = 1000;
   localparam int MAX_PULSE_US = 2000;
   localparam int FRAME_CYC    = CLOCK_FREQ / FRAME_HZ;
   localparam int MIN_CYC      = CLOCK_FREQ / 1_000_000 * MIN_PULSE_US;
   localparam int MAX_CYC      = CLOCK_FREQ / 1_000_000 * MAX_PULSE_US;
   localparam int STEP         = (MAX_CYC - MIN_CYC) / 255;
   localparam int N_CH         = 4;
   localparam int CNT_W        = 20;
   localparam int CTRL_W       = 8;
   localparam int ADDR_W       = $clog2(N_CH);

   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [CTRL_W-1:0] ctrl_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // Pulse length in cycles; wraps in 20 bits like the hardware adder.
   function automatic cnt_t pulse_width(ctrl_t code, int min_cyc, int step_cyc);
      return CNT_W'(min_cyc) + CNT_W'(code) * CNT_W'(step_cyc);
   endfunction

endpackage

// File: rtl/n_channel_servo_controller_if.sv
// Host write port of the servo controller: position code, channel select and strobe.
interface n_channel_servo_controller_if;
   import servo_pkg::*;

   ctrl_t control;
   addr_t address;
   logic  load;

   modport master (output control, output address, output load);
   modport slave  (input  control, input  address, input  load);

endinterface

// File: rtl/servo_pwm_channel.sv
// One servo channel: double-buffered position code and a registered pulse comparator.
// Shadow and enable copy into the active set only at the frame wrap.
module servo_pwm_channel
   import servo_pkg::*;
#(
   parameter int MIN_CYCLES  = MIN_CYC,
   parameter int STEP_CYCLES = STEP
) (
   input  logic  clock,
   input  logic  reset,
   input  cnt_t  count,
   input  logic  wrap,
   input  logic  wr,
   input  ctrl_t control,
   output logic  pwm
);

   ctrl_t shadow_r;
   ctrl_t active_r;
   logic  enable_r;
   logic  enable_active_r;
   logic  pwm_r;
   cnt_t  width_s;

   // host-side shadow copy and sticky enable
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_r <= 8'd0;
         enable_r <= 1'b0;
      end else if (wr) begin
         shadow_r <= control;
         enable_r <= 1'b1;
      end else begin
         shadow_r <= shadow_r;
         enable_r <= enable_r;
      end
   end

   // frame-aligned copy so a frame in progress is never altered
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active_r        <= 8'd0;
         enable_active_r <= 1'b0;
      end else if (wrap) begin
         active_r        <= shadow_r;
         enable_active_r <= enable_r;
      end else begin
         active_r        <= active_r;
         enable_active_r <= enable_active_r;
      end
   end

   always_comb begin
      width_s = pulse_width(active_r, MIN_CYCLES, STEP_CYCLES);
   end

   // registered pulse output, one cycle behind the counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pwm_r <= 1'b0;
      end else begin
         pwm_r <= enable_active_r & (count < width_s);
      end
   end

   assign pwm = pwm_r;

endmodule

// File: rtl/n_channel_servo_controller.sv
// Four-channel hobby-servo PWM generator sharing a single 20 ms frame counter.
// Frame length and pulse scaling are parameters so the frame can be shortened.
module n_channel_servo_controller
   import servo_pkg::*;
#(
   parameter int FRAME_CYCLES = FRAME_CYC,
   parameter int MIN_CYCLES   = MIN_CYC,
   parameter int STEP_CYCLES  = STEP
) (
   input  logic                          clock,
   input  logic                          reset,
   n_channel_servo_controller_if.slave   host,
   output logic [N_CH-1:0]               pwm
);

   cnt_t            count_r;
   logic            wrap_s;
   logic [N_CH-1:0] sel_s;

   assign wrap_s = (count_r == CNT_W'(FRAME_CYCLES - 1));

   // free-running frame counter shared by every channel
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= 20'd0;
      end else if (wrap_s) begin
         count_r <= 20'd0;
      end else begin
         count_r <= count_r + 20'd1;
      end
   end

   // one-hot write select; codes beyond the last channel match nothing
   always_comb begin
      sel_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         sel_s[i] = host.load & (host.address == ADDR_W'(i));
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      servo_pwm_channel #(
         .MIN_CYCLES  (MIN_CYCLES),
         .STEP_CYCLES (STEP_CYCLES)
      ) u_ch (
         .clock   (clock),
         .reset   (reset),
         .count   (count_r),
         .wrap    (wrap_s),
         .wr      (sel_s[g]),
         .control (host.control),
         .pwm     (pwm[g])
      );
   end

endmodule

// File: tb/tb_n_channel_servo_controller.sv
// Directed bench for the servo controller using a shortened 1000-cycle frame
// (min 50 cycles, step 2: code 0 -> 50, code 128 -> 306, code 255 -> 560).
module tb_n_channel_servo_controller;
   import servo_pkg::*;

   localparam int F  = 1000;
   localparam int MN = 50;
   localparam int ST = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] pwm;
   int         checks   = 0;
   int         failures = 0;
   logic [3:0] first_v;
   int         wid [4];
   int         n;
   int         nz;

   n_channel_servo_controller_if bus ();

   n_channel_servo_controller #(
      .FRAME_CYCLES (F),
      .MIN_CYCLES   (MN),
      .STEP_CYCLES  (ST)
   ) dut (
      .clock (clock),
      .reset (reset),
      .host  (bus),
      .pwm   (pwm)
   );

   always #10 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic write_ch(input logic [1:0] a, input logic [7:0] c);
      bus.load = 1'b1; bus.address = a; bus.control = c;
      @(negedge clock);
      bus.load = 1'b0;
   endtask

   // Waits for a frame start, then samples one whole frame; optionally writes at sample wr_at.
   task automatic measure(input int wr_at, input logic [1:0] wa, input logic [7:0] wc);
      int k;
      k = 0;
      while (pwm !== 4'b0000 && k < 2*F) begin @(negedge clock); k++; end
      check("wait_low", {31'd0, pwm === 4'b0000}, 32'd1);
      k = 0;
      do begin @(negedge clock); k++; end while (pwm === 4'b0000 && k < 2*F);
      check("wait_rise", {31'd0, pwm !== 4'b0000}, 32'd1);
      first_v = pwm;
      for (int c = 0; c < 4; c++) wid[c] = 0;
      for (int s = 0; s < F; s++) begin
         if (s > 0) @(negedge clock);
         for (int c = 0; c < 4; c++) if (pwm[c] === 1'b1) wid[c]++;
         if (s == wr_at) begin
            bus.load = 1'b1; bus.address = wa; bus.control = wc;
         end
         if (s == wr_at + 1) bus.load = 1'b0;
      end
   endtask

   initial begin
      bus.load = 1'b0; bus.address = 2'd0; bus.control = 8'd0;
      repeat (3) @(negedge clock);
      check("reset_pwm", {28'd0, pwm}, 32'd0);
      reset = 1'b0;

      nz = 0;
      repeat (2*F) begin @(negedge clock); if (pwm !== 4'b0000) nz++; end
      check("idle_two_frames", nz, 0);

      write_ch(2'd0, 8'd255);
      measure(-1, 2'd0, 8'd0);
      check("ch0_only_rise", {28'd0, first_v}, 32'd1);
      check("ch0_w255", wid[0], 560);
      check("ch1_off", wid[1], 0);
      check("ch3_off", wid[3], 0);
      @(negedge clock);
      check("period_exact", {28'd0, pwm}, 32'd1);

      write_ch(2'd1, 8'd0);
      write_ch(2'd2, 8'd128);
      measure(-1, 2'd0, 8'd0);
      check("three_rise_same_edge", {28'd0, first_v}, 32'd7);
      check("fc_ch0_w255", wid[0], 560);
      check("fc_ch1_w0", wid[1], 50);
      check("fc_ch2_w128", wid[2], 306);
      check("fc_ch3_off", wid[3], 0);

      measure(100, 2'd0, 8'd0);
      check("midpulse_ch0_kept", wid[0], 560);
      check("fd_ch2_w128", wid[2], 306);

      measure(F-2, 2'd1, 8'd255);
      check("fe_ch0_new_w0", wid[0], 50);
      check("fe_ch1_w0", wid[1], 50);

      measure(-1, 2'd0, 8'd0);
      check("wrap_write_old_width", wid[1], 50);
      check("ff_ch0_w0", wid[0], 50);

      measure(-1, 2'd0, 8'd0);
      check("wrap_write_new_width", wid[1], 560);
      check("fg_ch2_w128", wid[2], 306);

      @(negedge clock);
      repeat (20) @(negedge clock);
      check("before_reset_high", {28'd0, pwm}, 32'd7);
      reset = 1'b1;
      #1;
      check("reset_async_drop", {28'd0, pwm}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      @(negedge clock);
      n = 1;
      bus.load = 1'b1; bus.address = 2'd3; bus.control = 8'd128;
      @(negedge clock);
      n = 2;
      bus.load = 1'b0;
      while (pwm === 4'b0000 && n < 3*F) begin @(negedge clock); n++; end
      check("restart_rise_time", n, F+1);
      check("restart_only_ch3", {28'd0, pwm}, 32'd8);

      measure(-1, 2'd0, 8'd0);
      check("after_reset_rise", {28'd0, first_v}, 32'd8);
      check("after_reset_ch0_off", wid[0], 0);
      check("after_reset_ch3_w128", wid[3], 306);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
